// File: rtl/tlc1543_s00_axi_regs.sv
// tlc1543_s00_axi_regs: AXI4-Lite slave, four 32-bit R/W registers with per-register write pulses
//   s00_axi_aclk/areset : clock, async active-high reset
//   s00_axi_aw*/w*/b*   : write address/data/response channels
//   s00_axi_ar*/r*      : read address/data channels
//   slv_reg0..3         : register contents; reg_wr_pulse : one-cycle commit strobe per register
module tlc1543_s00_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg3,
  output logic [3:0]                      reg_wr_pulse
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, AW_HELD, W_HELD, RESP} wst_e;
  wst_e state_q, state_d;
  logic rdy_q, rvalid_q;
  logic [1:0] awidx_q, widx;
  logic [DW-1:0] wdata_q, rdata_q, wd;
  logic [DW/8-1:0] wstrb_q, ws;
  logic [3:0][DW-1:0] reg_q;
  logic [3:0] pulse_q;
  logic aw_hs, w_hs, ar_hs, commit;
  logic unused;
  assign unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr};
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset)
    if (s00_axi_areset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = commit ? RESP :
              state_q == RESP ? (s00_axi_bready ? IDLE : RESP) :
              aw_hs ? AW_HELD : w_hs ? W_HELD : state_q;
  end
  // rdy_q keeps every ready low until the first edge after reset release
  always_comb begin
    s00_axi_awready = rdy_q && (state_q == IDLE || state_q == W_HELD);
    s00_axi_wready  = rdy_q && (state_q == IDLE || state_q == AW_HELD);
    s00_axi_bvalid  = state_q == RESP;
    s00_axi_arready = rdy_q && !rvalid_q;
  end
  // Commit uses the held half of the transfer if captured earlier, else the live bus value
  always_comb begin
    aw_hs  = s00_axi_awvalid && s00_axi_awready;
    w_hs   = s00_axi_wvalid && s00_axi_wready;
    ar_hs  = s00_axi_arvalid && s00_axi_arready;
    commit = (aw_hs || state_q == AW_HELD) && (w_hs || state_q == W_HELD);
    widx   = state_q == AW_HELD ? awidx_q : s00_axi_awaddr[3:2];
    wd     = state_q == W_HELD ? wdata_q : s00_axi_wdata;
    ws     = state_q == W_HELD ? wstrb_q : s00_axi_wstrb;
  end
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset)
    if (s00_axi_areset) begin
      rdy_q    <= 1'b0;
      awidx_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      reg_q    <= '0;
      pulse_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (aw_hs) awidx_q <= s00_axi_awaddr[3:2];
      if (w_hs) begin
        wdata_q <= s00_axi_wdata;
        wstrb_q <= s00_axi_wstrb;
      end
      pulse_q <= commit ? 4'b0001 << widx : 4'b0000;
      for (int i = 0; i < DW/8; i++)
        if (commit && ws[i]) reg_q[widx][8*i +: 8] <= wd[8*i +: 8];
      if (ar_hs) begin
        rdata_q  <= reg_q[s00_axi_araddr[3:2]];
        rvalid_q <= 1'b1;
      end else if (rvalid_q && s00_axi_rready) rvalid_q <= 1'b0;
    end
  assign s00_axi_bresp  = 2'b00;
  assign s00_axi_rresp  = 2'b00;
  assign s00_axi_rdata  = rdata_q;
  assign s00_axi_rvalid = rvalid_q;
  assign slv_reg0 = reg_q[0];
  assign slv_reg1 = reg_q[1];
  assign slv_reg2 = reg_q[2];
  assign slv_reg3 = reg_q[3];
  assign reg_wr_pulse = pulse_q;
endmodule

// File: tb/tb_tlc1543_s00_axi_regs.sv
// tb_tlc1543_s00_axi_regs: scoreboard bench for the TLC1543 AXI4-Lite register block
module tb_tlc1543_s00_axi_regs;
  logic clk = 0, rst;
  logic [3:0] awaddr, araddr;
  logic [2:0] awprot = 3'd0, arprot = 3'd0;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata, r0, r1, r2, r3;
  logic [3:0] wstrb, pulse;
  logic [1:0] bresp, rresp;
  int n_cmp = 0, n_err = 0;
  logic [31:0] m [4];
  typedef struct packed {logic [3:0] p; logic [127:0] r;} bexp_t;
  bexp_t bq [$];
  logic [31:0] rq [$];

  tlc1543_s00_axi_regs dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .slv_reg0(r0), .slv_reg1(r1), .slv_reg2(r2), .slv_reg3(r3), .reg_wr_pulse(pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out", name);
  endtask

  // Monitor: pops expectations as the DUT presents responses
  initial begin
    bit prev_b = 0;
    bexp_t e;
    forever begin
      @(negedge clk);
      if (rst) prev_b = 0;
      else begin
        if (bvalid && !prev_b) begin
          if (bq.size() == 0) timeout("unexpected_bvalid");
          else begin
            e = bq.pop_front();
            chk("wr_pulse", 128'(pulse), 128'(e.p));
            chk("slv_regs", {r3, r2, r1, r0}, e.r);
            chk("bresp", 128'(bresp), 128'(0));
          end
        end
        if (bvalid && prev_b) chk("pulse_one_cycle", 128'(pulse), 128'(0));
        if (bvalid) chk("ready_in_resp", {awready, wready}, 128'(0));
        if (rvalid && rready) begin
          if (rq.size() == 0) timeout("unexpected_rvalid");
          else begin
            chk("rdata", 128'(rdata), 128'(rq.pop_front()));
            chk("rresp", 128'(rresp), 128'(0));
          end
        end
        prev_b = bvalid;
      end
    end
  end

  task automatic do_reset();
    rst = 1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
    @(negedge clk);
    chk("rst_outputs", {bvalid, rvalid, awready, wready, arready, pulse, rdata}, 128'(0));
    chk("rst_regs", {r3, r2, r1, r0}, 128'(0));
    @(posedge clk); #2;
    rst = 0;
    for (int i = 0; i < 4; i++) m[i] = 0;
    @(negedge clk);
    chk("ready_low_after_release", {awready, wready, arready}, 128'(0));
    @(posedge clk); #1;
    chk("ready_high_after_edge", {awready, wready, arready, bvalid, rvalid}, {3'b111, 2'b00});
  endtask

  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input int bdly);
    int cyc = 0, aws = lead > 0 ? lead : 0, wss = lead < 0 ? -lead : 0;
    bit ad = 0, wdn = 0, af, wf;
    for (int i = 0; i < 4; i++) if (s[i]) m[a[3:2]][8*i +: 8] = d[8*i +: 8];
    bq.push_back('{p: 4'b0001 << a[3:2], r: {m[3], m[2], m[1], m[0]}});
    awaddr = a; wdata = d; wstrb = s; bready = 0;
    awvalid = aws == 0; wvalid = wss == 0;
    while (!(ad && wdn)) begin
      @(negedge clk);
      af = awvalid && awready;
      wf = wvalid && wready;
      @(posedge clk); #1;
      if (af) begin awvalid = 0; ad = 1; end
      if (wf) begin wvalid = 0; wdn = 1; end
      cyc++;
      if (!ad && cyc >= aws) awvalid = 1;
      if (!wdn && cyc >= wss) wvalid = 1;
      if (cyc > 60) begin timeout("aw_w_handshake"); awvalid = 0; wvalid = 0; return; end
    end
    repeat (bdly) begin @(posedge clk); #1; end
    bready = 1;
    cyc = 0;
    forever begin
      @(negedge clk);
      af = bvalid && bready;
      @(posedge clk); #1;
      if (af) break;
      if (++cyc > 60) begin timeout("b_handshake"); break; end
    end
    bready = 0;
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] exp, input int rd);
    int cyc = 0;
    bit f;
    rq.push_back(exp);
    araddr = a; arvalid = 1;
    forever begin
      @(negedge clk);
      f = arvalid && arready;
      @(posedge clk); #1;
      if (f) break;
      if (++cyc > 60) begin timeout("ar_handshake"); arvalid = 0; return; end
    end
    arvalid = 0;
    repeat (rd) begin @(posedge clk); #1; end
    rready = 1;
    cyc = 0;
    forever begin
      @(negedge clk);
      f = rvalid && rready;
      @(posedge clk); #1;
      if (f) break;
      if (++cyc > 60) begin timeout("r_handshake"); break; end
    end
    rready = 0;
  endtask

  initial begin
    logic [31:0] base [4];
    logic [31:0] exp;
    logic [3:0] a;
    base[0] = 32'h0101FFFF; base[1] = 32'habcd0001; base[2] = 32'hdead0011; base[3] = 32'hbeef0011;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a = 4'(i * 4);
      axi_write(a, base[i], 4'hF, 0, 0);
      axi_read(a, m[i], 0);
    end
    axi_write(4'h4, 32'h11223344, 4'h5, 0, 0);
    chk("strobe_model", 128'(m[1]), 128'(32'hab220044));
    axi_read(4'h4, m[1], 1);
    axi_write(4'hC, 32'h0badf00d, 4'hF, 3, 5);
    axi_write(4'hC, 32'hcafe1234, 4'hF, 0, 0);
    axi_read(4'hC, m[3], 0);
    exp = m[2];
    fork
      axi_read(4'h8, exp, 0);
      axi_write(4'h8, 32'h12345678, 4'hF, 0, 0);
    join
    axi_read(4'h8, m[2], 0);
    axi_write(4'h4, 32'h55AA55AA, 4'hF, 0, 0);
    axi_read(4'h6, m[1], 0);
    axi_write(4'h1, 32'h0, 4'h0, -2, 1);
    for (int k = 0; k < 40; k++) begin
      a = 4'($urandom_range(0, 15));
      axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 6) - 3, $urandom_range(0, 3));
      a = 4'($urandom_range(0, 15));
      axi_read(a, m[a[3:2]], $urandom_range(0, 2));
    end
    awaddr = 4'h8; awvalid = 1;
    begin
      int cyc = 0;
      bit f;
      forever begin
        @(negedge clk);
        f = awvalid && awready;
        @(posedge clk); #1;
        if (f) break;
        if (++cyc > 60) begin timeout("aw_before_reset"); break; end
      end
    end
    awvalid = 0;
    repeat (2) @(posedge clk);
    #3;
    do_reset();
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 32'h0, 0);
    axi_write(4'h0, 32'h600dcafe, 4'hF, 1, 0);
    axi_read(4'h0, m[0], 0);
    repeat (5) @(posedge clk);
    chk("bq_drained", 128'(bq.size()), 128'(0));
    chk("rq_drained", 128'(rq.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
